// File: rtl/sparc_ifu_thrsched.sv
// sparc_ifu_thrsched: four-thread DEAD/RDY/WAIT tracker with round-robin F-stage pick and wait watchdog.
// Define SPARC_THRSCHED_WAKE_BYP_EN to let a thread woken by completion be picked in the same cycle.
module sparc_ifu_thrsched #(
    parameter logic [1:0]       RST_PTR  = 2'd3,
    parameter int               TMO_W    = 8,
    parameter logic [TMO_W-1:0] WAIT_TMO = 8'hff
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] thr_active,
    input  logic [3:0] wait_set,
    input  logic [3:0] completion,
    input  logic       stall_f,
    output logic [3:0] thr_f,
    output logic       thr_f_vld,
    output logic [3:0] thr_rdy,
    output logic [3:0] wait_tmo
);
`ifdef SPARC_THRSCHED_WAKE_BYP_EN
    localparam bit WAKE_BYP = 1'b1;
`else
    localparam bit WAKE_BYP = 1'b0;
`endif

    typedef enum logic [1:0] {DEAD = 2'd0, RDY = 2'd1, WAIT = 2'd2} thr_st_e;

    thr_st_e          st_q [4];
    thr_st_e          st_d [4];
    logic [TMO_W-1:0] cnt_q [4];
    logic [TMO_W-1:0] cnt_d [4];
    logic [3:0]       thr_f_q, thr_f_d, tmo_q, tmo_d, elig, keep;
    logic [1:0]       ptr_q, ptr_d, idx;
    logic             found;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_d[i] = !thr_active[i] ? DEAD :
                      st_q[i] == DEAD ? RDY :
                      (st_q[i] == RDY && wait_set[i] && !completion[i]) ? WAIT :
                      (st_q[i] == WAIT && completion[i]) ? RDY : st_q[i];
            elig[i] = thr_active[i] && ((st_q[i] == RDY && !wait_set[i]) ||
                      (WAKE_BYP && st_q[i] == WAIT && completion[i]));
            keep[i] = st_d[i] == RDY;
            cnt_d[i] = (st_d[i] != WAIT || st_q[i] != WAIT) ? '0 :
                       cnt_q[i] == WAIT_TMO ? cnt_q[i] : cnt_q[i] + TMO_W'(1);
            tmo_d[i] = st_d[i] == WAIT && st_q[i] == WAIT && cnt_q[i] != WAIT_TMO && cnt_d[i] == WAIT_TMO;
            thr_rdy[i] = st_q[i] == RDY;
        end
        found = 1'b0;
        idx = ptr_q;
        // Search order starts just past the last pick, wrapping 3->0.
        for (int k = 1; k <= 4; k++) begin
            if (!found && elig[ptr_q + 2'(k)]) begin
                found = 1'b1;
                idx = ptr_q + 2'(k);
            end
        end
        ptr_d = stall_f ? ptr_q : idx;
        thr_f_d = stall_f ? (thr_f_q & keep) : found ? (4'b1 << idx) : 4'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= '{default: DEAD};
            cnt_q   <= '{default: '0};
            thr_f_q <= '0;
            tmo_q   <= '0;
            ptr_q   <= RST_PTR;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            thr_f_q <= thr_f_d;
            tmo_q   <= tmo_d;
            ptr_q   <= ptr_d;
        end
    end

    assign thr_f     = thr_f_q;
    assign thr_f_vld = |thr_f_q;
    assign wait_tmo  = tmo_q;
endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// tb_sparc_ifu_thrsched: directed scenarios plus randomized traffic checked against a
// per-thread reference model of the scheduler.
module tb_sparc_ifu_thrsched;
`ifdef SPARC_THRSCHED_WAKE_BYP_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int D = 0, R = 1, W = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] thr_active = '0, wait_set = '0, completion = '0;
    logic       stall_f = 1'b0;
    logic [3:0] thr_f, thr_rdy, wait_tmo;
    logic       thr_f_vld;

    int total = 0, passed = 0;

    int         st [4];
    int         wc [4];
    logic [3:0] m_f, m_tmo;
    int         m_ptr;

    sparc_ifu_thrsched dut (
        .clk(clk), .reset(reset), .thr_active(thr_active), .wait_set(wait_set),
        .completion(completion), .stall_f(stall_f), .thr_f(thr_f),
        .thr_f_vld(thr_f_vld), .thr_rdy(thr_rdy), .wait_tmo(wait_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        total++;
        assert ($onehot0(thr_f)) passed++;
        else $error("FAIL onehot0 observed=%0h expected=onehot0", thr_f);
    end

    task automatic mreset();
        for (int i = 0; i < 4; i++) begin
            st[i] = D;
            wc[i] = 0;
        end
        m_f = '0;
        m_tmo = '0;
        m_ptr = 3;
    endtask

    task automatic mstep();
        int nst [4];
        logic [3:0] elig;
        int p;
        for (int i = 0; i < 4; i++) begin
            elig[i] = thr_active[i] && ((st[i] == R && !wait_set[i]) || (BYP && st[i] == W && completion[i]));
            if (!thr_active[i]) nst[i] = D;
            else if (st[i] == D) nst[i] = R;
            else if (st[i] == R && wait_set[i] && !completion[i]) nst[i] = W;
            else if (st[i] == W && completion[i]) nst[i] = R;
            else nst[i] = st[i];
        end
        if (stall_f) begin
            for (int i = 0; i < 4; i++) if (nst[i] != R) m_f[i] = 1'b0;
        end else begin
            m_f = '0;
            for (int k = 1; k <= 4; k++) begin
                p = (m_ptr + k) % 4;
                if (elig[p]) begin
                    m_f[p] = 1'b1;
                    m_ptr = p;
                    break;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_tmo[i] = 1'b0;
            if (nst[i] == W && st[i] == W) begin
                if (wc[i] < 255) begin
                    wc[i]++;
                    if (wc[i] == 255) m_tmo[i] = 1'b1;
                end
            end else wc[i] = 0;
            st[i] = nst[i];
        end
    endtask

    task automatic check_all(string tag);
        logic [3:0] mr;
        for (int i = 0; i < 4; i++) mr[i] = st[i] == R;
        chk({tag, ".thr_f"}, thr_f, m_f);
        chk({tag, ".vld"}, thr_f_vld, |m_f);
        chk({tag, ".rdy"}, thr_rdy, mr);
        chk({tag, ".tmo"}, wait_tmo, m_tmo);
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        if (reset) mreset();
        else mstep();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] t1_exp [5];
        int pulses, at, found;
        t1_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.thr_f", thr_f, 4'h0);
        chk("reset.vld", thr_f_vld, 1'b0);
        chk("reset.rdy", thr_rdy, 4'h0);
        chk("reset.tmo", wait_tmo, 4'h0);

        reset = 1'b0;
        thr_active = 4'hf;
        cyc("t1");
        chk("t1.first_rdy", thr_rdy, 4'hf);
        chk("t1.first_thr_f", thr_f, 4'h0);
        for (int j = 0; j < 5; j++) begin
            cyc("t1");
            chk("t1.rr", thr_f, t1_exp[j]);
            chk("t1.vld", thr_f_vld, 1'b1);
        end

        thr_active = 4'h5;
        wait_set = 4'h1;
        cyc("t2");
        wait_set = 4'h0;
        repeat (3) begin
            cyc("t2");
            chk("t2.only2", thr_f, 4'h4);
        end
        completion = 4'h1;
        cyc("t2");
        chk("t2.wake_n1", thr_f, BYP ? 4'h1 : 4'h4);
        completion = 4'h0;
        cyc("t2");
        chk("t2.wake_n2", thr_f, BYP ? 4'h4 : 4'h1);

        thr_active = 4'hf;
        cyc("t3");
        wait_set = 4'hf;
        cyc("t3");
        wait_set = 4'h0;
        repeat (3) cyc("t3");
        chk("t3.none", thr_f, 4'h0);
        chk("t3.none_vld", thr_f_vld, 1'b0);
        completion = 4'h8;
        cyc("t3");
        completion = 4'h0;
        cyc("t3");
        chk("t3.wake3", thr_f, 4'h8);

        completion = 4'hf;
        cyc("t4");
        completion = 4'h0;
        found = 0;
        for (int j = 0; j < 8 && found == 0; j++) begin
            if (thr_f == 4'h2) found = 1;
            else cyc("t4");
        end
        chk("t4.reach2", found, 1);
        stall_f = 1'b1;
        cyc("t4");
        chk("t4.hold", thr_f, 4'h2);
        thr_active = 4'hd;
        cyc("t4");
        chk("t4.dead_clr", thr_f, 4'h0);
        cyc("t4");
        chk("t4.still_clr", thr_f, 4'h0);
        stall_f = 1'b0;
        cyc("t4");
        chk("t4.resume", thr_f, 4'h4);

        thr_active = 4'hf;
        wait_set = 4'h1;
        cyc("t5");
        wait_set = 4'h0;
        pulses = 0;
        at = 0;
        for (int k = 1; k <= 260; k++) begin
            cyc("t5");
            if (wait_tmo[0]) begin
                pulses++;
                at = k;
            end
        end
        chk("t5.pulses", pulses, 1);
        chk("t5.pulse_at", at, 255);
        chk("t5.stays_wait", thr_rdy[0], 1'b0);
        completion = 4'h1;
        cyc("t5");
        chk("t5.woken", thr_rdy[0], 1'b1);
        wait_set = 4'h1;
        cyc("t5");
        chk("t5.zero_wait", thr_rdy[0], 1'b1);
        wait_set = 4'h0;
        completion = 4'h0;

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++) begin
                thr_active[i] = $urandom_range(7) != 0;
                wait_set[i]   = $urandom_range(5) == 0;
                completion[i] = $urandom_range(2) == 0;
            end
            stall_f = $urandom_range(4) == 0;
            cyc("rand");
        end

        thr_active = 4'hf;
        wait_set = 4'h0;
        completion = 4'h0;
        stall_f = 1'b0;
        repeat (3) cyc("t6");
        #2 reset = 1'b1;
        #1;
        chk("t6.async_thr_f", thr_f, 4'h0);
        chk("t6.async_vld", thr_f_vld, 1'b0);
        chk("t6.async_rdy", thr_rdy, 4'h0);
        chk("t6.async_tmo", wait_tmo, 4'h0);
        mreset();
        cyc("t6");
        reset = 1'b0;
        repeat (4) cyc("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
